// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: walks a one-hot phase through NSTAGE phases with
// per-phase stall/skip, halts at instruction boundaries and counts run cycles and retires.
module phase_sequencer #(
    parameter int unsigned NSTAGE = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NSTAGE-1:0] stall,
    input  logic [NSTAGE-1:0] skip,
    input  logic              halt_req,
    input  logic              step,
    output logic [NSTAGE-1:0] stage_en,
    output logic [NSTAGE-1:0] cur_stage,
    output logic              retire,
    output logic              halted,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instret
);

    localparam logic [NSTAGE-1:0] Phase0 = {{(NSTAGE-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        StRun,
        StHalted
    } state_t;

    state_t              r_state;
    logic [NSTAGE-1:0]   r_cur_stage;
    logic                r_halted;
    logic [CNT_W-1:0]    r_cycle_cnt;
    logic [CNT_W-1:0]    r_instret;

    logic [NSTAGE-1:0]   w_next_stage;
    logic                w_found;
    logic                w_commit;
    logic                w_unused_skip0;

    // Phase 0 can never be skipped, so its skip bit is intentionally unused.
    assign w_unused_skip0 = skip[0];

    assign stage_en = r_cur_stage & ~stall & {NSTAGE{r_state == StRun}};
    assign w_commit = |stage_en;

    // Lowest non-skipped phase above the current one; none found means wrap to phase 0.
    always_comb begin
        w_next_stage = '0;
        w_found      = 1'b0;
        for (int i = 0; i < int'(NSTAGE); i++) begin
            for (int j = 1; j < int'(NSTAGE); j++) begin
                if (r_cur_stage[i] && (j > i) && !skip[j] && !w_found) begin
                    w_next_stage[j] = 1'b1;
                    w_found         = 1'b1;
                end
            end
        end
        if (!w_found) begin
            w_next_stage[0] = 1'b1;
        end
    end

    // A wrap retires the instruction, except a phase-0 commit with every later phase skipped.
    assign retire = w_commit & ~w_found & ~r_cur_stage[0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= StRun;
            r_cur_stage <= Phase0;
            r_halted    <= 1'b0;
            r_cycle_cnt <= '0;
            r_instret   <= '0;
        end else begin
            unique case (r_state)
                StRun: begin
                    r_cycle_cnt <= r_cycle_cnt + CntOne;
                    if (w_commit) begin
                        r_cur_stage <= w_next_stage;
                    end
                    if (retire) begin
                        r_instret <= r_instret + CntOne;
                        if (halt_req) begin
                            r_state     <= StHalted;
                            r_halted    <= 1'b1;
                            r_cur_stage <= Phase0;
                        end
                    end
                end
                StHalted: begin
                    r_cur_stage <= Phase0;
                    if (step || !halt_req) begin
                        r_state  <= StRun;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state <= StRun;
                end
            endcase
        end
    end

    assign cur_stage = r_cur_stage;
    assign halted    = r_halted;
    assign cycle_cnt = r_cycle_cnt;
    assign instret   = r_instret;

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: directed scenarios plus random stall/skip/halt
// traffic, checked against an integer-phase reference model; a CNT_W=4 copy checks wrapping.
module tb_phase_sequencer;

    localparam int NS = 5;

    logic          CLK = 1'b0;
    logic          RST;
    logic [NS-1:0] stall;
    logic [NS-1:0] skip;
    logic          halt_req;
    logic          step;

    logic [NS-1:0] stage_en, cur_stage;
    logic          retire, halted;
    logic [31:0]   cycle_cnt, instret;

    logic [NS-1:0] stage_en_w, cur_stage_w;
    logic          retire_w, halted_w;
    logic [3:0]    cycle_cnt_w, instret_w;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: phase as an integer index, counters kept wide.
    int              m_ph;
    bit              m_halted;
    longint unsigned m_cyc;
    longint unsigned m_ret;

    always #5 CLK = ~CLK;

    phase_sequencer #(.NSTAGE(NS), .CNT_W(32)) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .stall     (stall),
        .skip      (skip),
        .halt_req  (halt_req),
        .step      (step),
        .stage_en  (stage_en),
        .cur_stage (cur_stage),
        .retire    (retire),
        .halted    (halted),
        .cycle_cnt (cycle_cnt),
        .instret   (instret)
    );

    phase_sequencer #(.NSTAGE(NS), .CNT_W(4)) u_dut_w (
        .CLK       (CLK),
        .RST       (RST),
        .stall     (stall),
        .skip      (skip),
        .halt_req  (halt_req),
        .step      (step),
        .stage_en  (stage_en_w),
        .cur_stage (cur_stage_w),
        .retire    (retire_w),
        .halted    (halted_w),
        .cycle_cnt (cycle_cnt_w),
        .instret   (instret_w)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int next_ph(input int ph, input logic [NS-1:0] sk);
        for (int j = ph + 1; j < NS; j++) begin
            if (!sk[j]) return j;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_ph     = 0;
        m_halted = 1'b0;
        m_cyc    = 0;
        m_ret    = 0;
    endtask

    // Starts and ends on a falling edge: drive, check combinational and registered
    // outputs against the model, then advance the model across the rising edge.
    task automatic do_cycle(input logic [NS-1:0] st, input logic [NS-1:0] sk,
                            input logic hr, input logic sp);
        int            nph;
        bit            commit;
        bit            exp_ret;
        logic [NS-1:0] exp_en;
        logic [NS-1:0] exp_cur;
        stall    = st;
        skip     = sk;
        halt_req = hr;
        step     = sp;
        nph      = next_ph(m_ph, sk);
        commit   = !m_halted && !st[m_ph];
        exp_ret  = commit && (nph == 0) && (m_ph != 0);
        exp_cur  = NS'(1) << m_ph;
        exp_en   = commit ? exp_cur : '0;
        #1;
        check("stage_en",    64'(stage_en),    64'(exp_en));
        check("retire",      64'(retire),      64'(exp_ret));
        check("cur_stage",   64'(cur_stage),   64'(exp_cur));
        check("halted",      64'(halted),      64'(m_halted));
        check("cycle_cnt",   64'(cycle_cnt),   64'(m_cyc[31:0]));
        check("instret",     64'(instret),     64'(m_ret[31:0]));
        check("retire_w",    64'(retire_w),    64'(exp_ret));
        check("cycle_cnt_w", 64'(cycle_cnt_w), 64'(m_cyc[3:0]));
        check("instret_w",   64'(instret_w),   64'(m_ret[3:0]));
        @(posedge CLK);
        if (!m_halted) begin
            m_cyc++;
            if (commit) begin
                if (exp_ret) begin
                    m_ret++;
                    if (hr) m_halted = 1'b1;
                end
                m_ph = nph;
            end
        end else if (sp || !hr) begin
            m_halted = 1'b0;
        end
        @(negedge CLK);
    endtask

    // Starts and ends on a falling edge; reset is raised between clock edges.
    task automatic do_reset();
        #2;
        RST = 1'b1;
        #1;
        check("rst_cur_stage", 64'(cur_stage),   64'd1);
        check("rst_cycle_cnt", 64'(cycle_cnt),   64'd0);
        check("rst_instret",   64'(instret),     64'd0);
        check("rst_retire",    64'(retire),      64'd0);
        check("rst_halted",    64'(halted),      64'd0);
        check("rst_cycle_w",   64'(cycle_cnt_w), 64'd0);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [NS-1:0] st;
        logic [NS-1:0] sk;
        logic          hr;
        logic          sp;

        RST      = 1'b1;
        stall    = '0;
        skip     = '0;
        halt_req = 1'b0;
        step     = 1'b0;
        model_reset();

        @(negedge CLK);
        #1;
        check("init_cur_stage", 64'(cur_stage), 64'd1);
        check("init_cycle_cnt", 64'(cycle_cnt), 64'd0);
        check("init_halted",    64'(halted),    64'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Free run: retire every 5th cycle
        repeat (20) do_cycle('0, '0, 1'b0, 1'b0);
        check("s1_instret",   64'(instret),     64'd4);
        check("s1_cycle_cnt", 64'(cycle_cnt),   64'd20);
        check("s1_cycle_w",   64'(cycle_cnt_w), 64'd4);

        // Memory wait held in MA for 7 cycles
        repeat (3) do_cycle('0, '0, 1'b0, 1'b0);
        repeat (7) do_cycle(5'b01000, '0, 1'b0, 1'b0);
        check("s2_held_ma", 64'(cur_stage), 64'd8);
        repeat (2) do_cycle('0, '0, 1'b0, 1'b0);
        check("s2_cycle_cnt", 64'(cycle_cnt), 64'd32);
        check("s2_instret",   64'(instret),   64'd5);

        // MA skipped: 4-cycle instructions
        repeat (8) do_cycle('0, 5'b01000, 1'b0, 1'b0);
        check("s3_cycle_cnt", 64'(cycle_cnt), 64'd40);
        check("s3_instret",   64'(instret),   64'd7);

        // Halt requested in DC, then single step
        do_cycle('0, '0, 1'b0, 1'b0);
        repeat (4) do_cycle('0, '0, 1'b1, 1'b0);
        check("s4_halted",    64'(halted),    64'd1);
        check("s4_instret",   64'(instret),   64'd8);
        repeat (5) do_cycle('0, '0, 1'b1, 1'b0);
        check("s4_frozen",    64'(cycle_cnt), 64'd45);
        do_cycle('0, '0, 1'b1, 1'b1);
        repeat (5) do_cycle('0, '0, 1'b1, 1'b0);
        check("s4_step_halted",  64'(halted),    64'd1);
        check("s4_step_instret", 64'(instret),   64'd9);
        check("s4_step_cycle",   64'(cycle_cnt), 64'd50);
        repeat (2) do_cycle('0, '0, 1'b1, 1'b0);
        do_cycle('0, '0, 1'b0, 1'b0);

        // Reset taken in EX with cycle_cnt 37
        do_reset();
        repeat (37) do_cycle('0, '0, 1'b0, 1'b0);
        check("s5_in_ex",    64'(cur_stage), 64'd4);
        check("s5_cycle_37", 64'(cycle_cnt), 64'd37);
        do_reset();

        // Stall on phase 0 straight out of reset
        repeat (3) do_cycle(5'b00001, '0, 1'b0, 1'b0);
        check("s5_first_hold", 64'(cycle_cnt), 64'd3);
        do_cycle('0, '0, 1'b0, 1'b0);

        // Narrow counters wrap after 16 retires / 16 cycles
        do_reset();
        repeat (80) do_cycle('0, '0, 1'b0, 1'b0);
        check("s6_instret",   64'(instret),     64'd16);
        check("s6_instret_w", 64'(instret_w),   64'd0);
        check("s6_cycle_w",   64'(cycle_cnt_w), 64'd0);

        // Random traffic
        hr = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                for (int b = 0; b < NS; b++) st[b] = ($urandom_range(0, 3) == 0);
                sk = NS'($urandom);
                if ($urandom_range(0, 24) == 0) hr = ~hr;
                sp = ($urandom_range(0, 7) == 0);
                do_cycle(st, sk, hr, sp);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
